// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro: IFU_ZERO_SKIP_EN (all-zero slots are treated as padding).
package ifu_pkg;

  localparam int         IM_WORDS = 64;
  localparam int         WA_W     = 6;
  localparam int         SEL_W    = 5;
  localparam logic [1:0] OPC_32   = 2'b11;

  typedef logic [31:0] slot_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    HOLD
  } ifu_state_e;

endpackage

// File: rtl/ifu_slot_classify.sv
// Selects the active 32-bit slot from a captured word pair and classifies it.
// Compressed slots are returned zero-extended from their low half.
module ifu_slot_classify
  import ifu_pkg::*;
(
  input  logic [63:0] bundle,
  input  logic        sel_odd,
  output logic [31:0] slot_data,
  output logic        slot_is_c,
  output logic        slot_zero
);

  slot_t slot;

  // Slot mux, compressed/zero detection and zero-extension
  always_comb begin
    slot      = sel_odd ? bundle[31:0] : bundle[63:32];
    slot_is_c = (slot[1:0] != OPC_32);
    slot_zero = (slot == '0);
    slot_data = slot_is_c ? {16'h0000, slot[15:0]} : slot;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads word pairs from the 64-word instruction
// memory, scans each slot in order and issues it to decode over valid/ready.
// Redirects from execute restart fetch at the given word address.
// Optional build macro: IFU_ZERO_SKIP_EN -- when defined, all-zero slots are
// skipped as padding; when undefined they are issued as compressed zeros.
//
// state | meaning
// IDLE  | stopped; waits for fetch_en, redirects only update wa
// LOAD  | pc_sel = wa[5:1]; word pair captured at the edge
// SCAN  | classify slot at wa; issue it, or skip padding
// HOLD  | instruction presented; waits for inst_ready
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  output logic [4:0]       pc_sel,
  input  logic [63:0]      im_bundle,
  input  logic             redirect_valid,
  input  logic [5:0]       redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_data,
  output logic             inst_is_c,
  output logic [5:0]       inst_pc,
  output logic [CNT_W-1:0] issued_count
);

`ifdef IFU_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  ifu_state_e       state_q, state_d;
  logic [WA_W-1:0]  wa_q, wa_d;
  logic [63:0]      bundle_q, bundle_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      inst_data_q, inst_data_d;
  logic             inst_is_c_q, inst_is_c_d;
  logic [WA_W-1:0]  inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0] issued_count_q, issued_count_d;

  logic [31:0]      slot_data;
  logic             slot_is_c;
  logic             slot_zero;
  logic [WA_W-1:0]  wa_inc;
  ifu_state_e       adv_state;
  logic             handshake;

  ifu_slot_classify u_classify (
    .bundle    (bundle_q),
    .sel_odd   (wa_q[0]),
    .slot_data (slot_data),
    .slot_is_c (slot_is_c),
    .slot_zero (slot_zero)
  );

  // Moving past an odd slot means the current pair is exhausted
  assign wa_inc    = wa_q + WA_W'(1);
  assign adv_state = wa_q[0] ? LOAD : SCAN;
  assign handshake = inst_valid_q & inst_ready;

  // Next-state, address and output-register computation
  always_comb begin
    state_d        = state_q;
    wa_d           = wa_q;
    bundle_d       = bundle_q;
    inst_valid_d   = inst_valid_q;
    inst_data_d    = inst_data_q;
    inst_is_c_d    = inst_is_c_q;
    inst_pc_d      = inst_pc_q;
    issued_count_d = issued_count_q;

    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          wa_d = redirect_pc;
        end else if (fetch_en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        bundle_d = im_bundle;
        state_d  = SCAN;
      end
      SCAN: begin
        if (ZERO_SKIP && slot_zero) begin
          wa_d    = wa_inc;
          state_d = adv_state;
        end else begin
          inst_data_d  = slot_data;
          inst_is_c_d  = slot_is_c;
          inst_pc_d    = wa_q;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          inst_valid_d = 1'b0;
          if (issued_count_q != {CNT_W{1'b1}}) begin
            issued_count_d = issued_count_q + CNT_W'(1);
          end
          wa_d    = wa_inc;
          state_d = fetch_en ? adv_state : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything except a stopped unit; a handshake
    // completing in the same cycle has already been counted above.
    if (redirect_valid && (state_q != IDLE)) begin
      wa_d         = redirect_pc;
      inst_valid_d = 1'b0;
      state_d      = LOAD;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wa_q           <= '0;
      bundle_q       <= '0;
      inst_valid_q   <= 1'b0;
      inst_data_q    <= '0;
      inst_is_c_q    <= 1'b0;
      inst_pc_q      <= '0;
      issued_count_q <= '0;
    end else begin
      state_q        <= state_d;
      wa_q           <= wa_d;
      bundle_q       <= bundle_d;
      inst_valid_q   <= inst_valid_d;
      inst_data_q    <= inst_data_d;
      inst_is_c_q    <= inst_is_c_d;
      inst_pc_q      <= inst_pc_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign pc_sel       = wa_q[WA_W-1:1];
  assign inst_valid   = inst_valid_q;
  assign inst_data    = inst_data_q;
  assign inst_is_c    = inst_is_c_q;
  assign inst_pc      = inst_pc_q;
  assign issued_count = issued_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run checked against a transaction-level fetch model.
// Build macro IFU_ZERO_SKIP_EN selects the padding-skip expectations.
module tb_instr_fetch_unit;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_en;
  logic [4:0]       pc_sel;
  logic [63:0]      im_bundle;
  logic             redirect_valid;
  logic [5:0]       redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst_data;
  logic             inst_is_c;
  logic [5:0]       inst_pc;
  logic [CNT_W-1:0] issued_count;

  logic [31:0] mem [64];

  int n_chk = 0;
  int n_bad = 0;

  logic [5:0]       exp_pc;
  logic [CNT_W-1:0] exp_cnt;
  logic             hs;

  instr_fetch_unit #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .pc_sel         (pc_sel),
    .im_bundle      (im_bundle),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_is_c      (inst_is_c),
    .inst_pc        (inst_pc),
    .issued_count   (issued_count)
  );

  always #5 clk = ~clk;

  assign im_bundle = {mem[{pc_sel, 1'b0}], mem[{pc_sel, 1'b1}]};

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      tick();
      if (inst_valid) break;
    end
    if (i == 60) chk_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Reference: expected decode view of the word at address a
  function automatic logic exp_c(input logic [5:0] a);
    return mem[a][1:0] != 2'b11;
  endfunction

  function automatic logic [31:0] exp_data(input logic [5:0] a);
    return exp_c(a) ? {16'h0000, mem[a][15:0]} : mem[a];
  endfunction

  // Reference: first address at or after a that will actually be issued
  function automatic logic [5:0] next_issuable(input logic [5:0] a);
    logic [5:0] p;
    p = a;
`ifdef IFU_ZERO_SKIP_EN
    for (int k = 0; k < 64 && mem[p] == 32'h0; k++) p = p + 6'd1;
`endif
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 6'd0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [5:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h0000_0100;
    mem[0]  = 32'h0000_0000;
    mem[1]  = 32'h0000_40F9;
    mem[12] = 32'h41C0_D213;

    // Reset values
    reset = 1'b1;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 6'd0;
    repeat (3) tick();
    chk_val("rst_valid", inst_valid, 0);
    chk_val("rst_data", inst_data, 0);
    chk_val("rst_is_c", inst_is_c, 0);
    chk_val("rst_pc", inst_pc, 0);
    chk_val("rst_count", issued_count, 0);
    chk_val("rst_pc_sel", pc_sel, 0);

    // Startup from a zero slot at address 0
    reset = 1'b0;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
`ifdef IFU_ZERO_SKIP_EN
    chk_val("skip_e3_valid", inst_valid, 0);
    tick();
    chk_val("skip_valid", inst_valid, 1);
    chk_val("skip_pc", inst_pc, 1);
    chk_val("skip_data", inst_data, 32'h0000_40F9);
    chk_val("skip_is_c", inst_is_c, 1);
`else
    chk_val("zero_valid", inst_valid, 1);
    chk_val("zero_pc", inst_pc, 0);
    chk_val("zero_data", inst_data, 0);
    chk_val("zero_is_c", inst_is_c, 1);
`endif
    inst_ready = 1'b0;
    tick();
    chk_val("hold_valid", inst_valid, 1);
    reset = 1'b1;
    tick();
    chk_val("midrst_valid", inst_valid, 0);
    chk_val("midrst_count", issued_count, 0);
    chk_val("midrst_pc_sel", pc_sel, 0);

    // 32-bit instruction at word 12
    reset = 1'b0;
    tick();
    redirect_to(6'd12);
    chk_val("w12_pc_sel", pc_sel, 6);
    wait_valid("w12");
    chk_val("w12_pc", inst_pc, 12);
    chk_val("w12_data", inst_data, 32'h41C0_D213);
    chk_val("w12_is_c", inst_is_c, 0);

    // Backpressure at address 3
    exp_cnt = '0;
    redirect_to(6'd3);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      chk_val("bp_valid", inst_valid, 1);
      chk_val("bp_pc", inst_pc, 3);
      chk_val("bp_data", inst_data, exp_data(6'd3));
      chk_val("bp_count", issued_count, exp_cnt);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk_val("bp_count_after", issued_count, exp_cnt);
    chk_val("bp_valid_after", inst_valid, 0);
    chk_val("bp_pc_sel", pc_sel, 2);
    wait_valid("bp_next");
    chk_val("bp_next_pc", inst_pc, 4);

    // Redirect colliding with a completing handshake
    redirect_to(6'd8);
    wait_valid("col");
    chk_val("col_pc", inst_pc, 8);
    inst_ready = 1'b1;
    redirect_to(6'd23);
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk_val("col_count", issued_count, exp_cnt);
    chk_val("col_valid", inst_valid, 0);
    chk_val("col_pc_sel", pc_sel, 11);
    wait_valid("col_next");
    chk_val("col_next_pc", inst_pc, 23);

    // Wrap-around from the top of memory
    redirect_to(6'd62);
    inst_ready = 1'b1;
    wait_valid("wrap62");
    chk_val("wrap_pc62", inst_pc, 62);
    wait_valid("wrap63");
    chk_val("wrap_pc63", inst_pc, 63);
    tick();
    chk_val("wrap_pc_sel", pc_sel, 0);
    wait_valid("wrap0");
    chk_val("wrap_pc0", inst_pc, next_issuable(6'd0));
    exp_cnt = exp_cnt + 2'd2;
    chk_val("wrap_count", issued_count, exp_cnt);
    inst_ready = 1'b0;

    // Throughput with ready tied high: 8 instructions in 21 edges
    mem[0] = 32'h0000_0013;
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    repeat (20) tick();
    chk_val("tput_20", issued_count, 7);
    tick();
    chk_val("tput_21", issued_count, 8);

    // Randomized run against the transaction model
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    mem[5] = 32'h0000_0013;
    do_reset();
    exp_pc = next_issuable(6'd0);
    exp_cnt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (inst_valid) begin
        chk_val("rnd_pc", inst_pc, exp_pc);
        chk_val("rnd_data", inst_data, exp_data(exp_pc));
        chk_val("rnd_is_c", inst_is_c, exp_c(exp_pc));
      end
      chk_val("rnd_count", issued_count, exp_cnt);
      inst_ready = ($urandom_range(0, 3) != 0);
      fetch_en = ($urandom_range(0, 9) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = 6'($urandom);
      hs = inst_valid && inst_ready;
      if (hs) begin
        if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        exp_pc = next_issuable(exp_pc + 6'd1);
      end
      if (redirect_valid) exp_pc = next_issuable(redirect_pc);
      tick();
    end
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    inst_ready = 1'b0;
    wait_valid("rnd_drain");
    chk_val("rnd_drain_pc", inst_pc, exp_pc);
    chk_val("rnd_drain_count", issued_count, exp_cnt);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
